alu_display_core: RTL and testbench
===================================

Name: alu_display_core

Overview:
Parametrised ALU-plus-display engine for the push-button calculator, generalised in operand width and digit count. It captures operands and the opcode from debounced push-button edges and computes a registered result with carry. A multi-cycle double-dabble converter turns the result into BCD, and a time-multiplexed scanner drives an N-digit anode-select bus. It sits between the debouncers and the seven-segment decoder, replacing the separate ALU, binary-to-BCD converter, anode selector and digit mux.

Parameters:
WIDTH, 8, operand width in bits; the result is WIDTH+1 bits.
DIGITS, 4, display digits: DIGITS-1 numeric digits plus 1 opcode-letter digit. Constraint: 10^(DIGITS-1) > 2^(WIDTH+1)-1.
SCAN_DIV, 16, clocks each digit stays enabled (>=1).

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  synchronous, active-high reset.
sw  input  WIDTH  operand switches.
pb_a  input  1  debounced level; load A.
pb_b  input  1  debounced level; load B.
pb_op  input  1  debounced level; advance opcode.
LED  output  WIDTH  RES[WIDTH-1:0].
carry  output  1  RES[WIDTH].
busy  output  1  high while the BCD converter is in CONV or LATCH.
AN_SEL  output  DIGITS  active-low one-hot anode enable; bit 0 is the rightmost (ones) digit.
digit_code  output  4  BCD digit or letter code for the enabled digit.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high; it has priority over every other event.
- Reset values: A=0, B=0, op=ADD, RES=0, LED=0, carry=0, busy=0, converter=IDLE, pending=0, display BCD=0, scan index=0, prescaler=0, AN_SEL={1..1,0}, digit_code=0, edge registers=0.
- Edge detect: press event on a button = level high and registered previous level low. A held button produces exactly one event.
- Event actions, taken at the edge after detection:
  - pb_a: A<=sw.
  - pb_b: B<=sw.
  - pb_op: op<=(op==5)?0:op+1.
  - Simultaneous events are all applied in the same cycle.
  - Any event raises recompute.
- Opcodes (letter code = 4'hA+op):
  - 0 ADD: RES = A+B, carry-out in bit WIDTH.
  - 1 SUB: RES = {borrow, (A-B) mod 2^WIDTH}, with borrow=(A<B).
  - 2 AND, 3 OR, 4 XOR: RES = {0, A op B}.
  - 5 SHL: RES = {A, 1'b0}.
- Result timing: RES registers at the edge after recompute (1 clock after the A/B/op update) and sets a new-result flag.
- Converter FSM:
  - IDLE -> CONV when new-result or pending is set; samples RES; busy=1.
  - CONV: WIDTH+1 shift/add-3 iterations, one per clock.
  - CONV -> LATCH after the last iteration.
  - LATCH: display BCD <= converted value (single-cycle atomic update).
  - LATCH -> IDLE.
  - A new result arriving during CONV or LATCH sets pending. The conversion in flight completes; on IDLE the converter restarts with the latest RES. pending clears when sampled.
  - The display never shows a partial conversion.
- Latency: from the edge that loads A/B/op to the display BCD update = WIDTH+4 clocks (12 for WIDTH=8).
- Scan:
  - The prescaler counts 0..SCAN_DIV-1; at wrap, index <= (index==DIGITS-1)?0:index+1.
  - AN_SEL = ~(1<<index).
  - digit_code = BCD digit[index] for index<DIGITS-1, else the op letter code.
  - AN_SEL and digit_code are registered together, so they never mismatch.
- Reset mid-conversion: the FSM aborts to IDLE and busy=0 on the next edge.

Test Plan:
1. Assert Reset 2 cycles, release -> LED=0, carry=0, busy=0, AN_SEL=4'b1110, digit_code=0; when index 3 is reached, digit_code=4'hA.
2. sw=200, pulse pb_a; sw=100, pulse pb_b (ADD) -> LED=8'h2C, carry=1; busy high for exactly 10 cycles; display digits 3,0,0 appear 12 clocks after the B load.
3. One pb_op pulse -> SUB, RES=100, carry=0, letter 4'hB. Then A=5, B=9 -> LED=8'hFC, carry=1, digits 5,0,8.
4. Hold pb_op high for 40 cycles -> op advances exactly once. Six separate pulses from ADD -> op wraps back to ADD (4'hA).
5. Load A, then pulse pb_b 3 cycles into CONV -> pending set; first conversion completes, second starts on return to IDLE; the final display matches the second RES; no intermediate digit value ever mixes the two results.
6. SCAN_DIV=4, DIGITS=4: AN_SEL steps 1110, 1101, 1011, 0111, 1110 every 4 clocks. Assert Reset during CONV -> busy=0, display digits 0, AN_SEL=1110 on the next edge.

Source files
------------

// File: rtl/alu_display_core.sv
// Push-button calculator core: edge-detected operand/opcode capture, registered ALU,
// multi-cycle double-dabble BCD conversion and a time-multiplexed anode/digit scanner.
module alu_display_core #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  sw,
    input  logic              pb_a,
    input  logic              pb_b,
    input  logic              pb_op,
    output logic [WIDTH-1:0]  LED,
    output logic              carry,
    output logic              busy,
    output logic [DIGITS-1:0] AN_SEL,
    output logic [3:0]        digit_code
);

    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned BW = 4 * (DIGITS - 1);
    localparam int unsigned CW = $clog2(RW);
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LATCH
    } conv_state_t;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    opcode_t          op;
    logic             prev_a;
    logic             prev_b;
    logic             prev_op;
    logic             ev_a;
    logic             ev_b;
    logic             ev_op;
    logic             recompute;
    logic             new_result;
    logic [RW-1:0]    res;
    logic [RW-1:0]    alu;

    assign ev_a  = pb_a  & ~prev_a;
    assign ev_b  = pb_b  & ~prev_b;
    assign ev_op = pb_op & ~prev_op;

    always_comb begin
        alu = '0;
        case (op)
            OP_ADD:  alu = {1'b0, a} + {1'b0, b};
            OP_SUB:  alu = {(a < b), a - b};
            OP_AND:  alu = {1'b0, a & b};
            OP_OR:   alu = {1'b0, a | b};
            OP_XOR:  alu = {1'b0, a ^ b};
            OP_SHL:  alu = {a, 1'b0};
            default: alu = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a          <= '0;
            b          <= '0;
            op         <= OP_ADD;
            prev_a     <= 1'b0;
            prev_b     <= 1'b0;
            prev_op    <= 1'b0;
            recompute  <= 1'b0;
            new_result <= 1'b0;
            res        <= '0;
        end else begin
            prev_a  <= pb_a;
            prev_b  <= pb_b;
            prev_op <= pb_op;
            if (ev_a)  a  <= sw;
            if (ev_b)  b  <= sw;
            if (ev_op) op <= (op == OP_SHL) ? OP_ADD : opcode_t'(op + 3'd1);
            recompute  <= ev_a | ev_b | ev_op;
            new_result <= recompute;
            if (recompute) res <= alu;
        end
    end

    assign LED   = res[WIDTH-1:0];
    assign carry = res[WIDTH];

    conv_state_t   state;
    logic [CW-1:0] iter;
    logic [RW-1:0] bin;
    logic [BW-1:0] bcd;
    logic [BW-1:0] bcd_adj;
    logic [BW-1:0] disp;
    logic          pending;

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < DIGITS - 1; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // The display register only changes in LATCH, so a conversion in flight is never visible.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            pending <= 1'b0;
            iter    <= '0;
            bin     <= '0;
            bcd     <= '0;
            disp    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_result || pending) begin
                        state   <= CONV;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                        bin     <= res;
                        bcd     <= '0;
                        iter    <= '0;
                    end
                end
                CONV: begin
                    bcd <= BW'({bcd_adj, bin[RW-1]});
                    bin <= {bin[RW-2:0], 1'b0};
                    if (new_result) pending <= 1'b1;
                    if (iter == CW'(WIDTH)) state <= LATCH;
                    else                    iter  <= iter + CW'(1);
                end
                LATCH: begin
                    disp  <= bcd;
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (new_result) pending <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_n;
    logic          wrap;
    logic [3:0]    letter;
    logic [3:0]    digit_n;

    assign wrap   = (presc == PW'(SCAN_DIV - 1));
    assign letter = 4'hA + 4'(op);

    always_comb begin
        idx_n = idx;
        if (wrap) idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end

    always_comb begin
        digit_n = letter;
        if (idx_n != IW'(DIGITS - 1)) digit_n = disp[4*idx_n +: 4];
    end

    // Anode select and digit code come from the same next index so they always agree.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            presc      <= '0;
            idx        <= '0;
            AN_SEL     <= ~DIGITS'(1);
            digit_code <= '0;
        end else begin
            presc      <= wrap ? '0 : presc + PW'(1);
            idx        <= idx_n;
            AN_SEL     <= ~(DIGITS'(1) << idx_n);
            digit_code <= digit_n;
        end
    end

endmodule

// File: tb/tb_alu_display_core.sv
// Bench for alu_display_core: a behavioural model tracks operands, results and
// conversion scheduling; a negedge process compares every output each cycle.
module tb_alu_display_core;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int SD = 4;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [W-1:0] sw;
    logic         pb_a;
    logic         pb_b;
    logic         pb_op;
    logic [W-1:0] LED;
    logic         carry;
    logic         busy;
    logic [D-1:0] AN_SEL;
    logic [3:0]   digit_code;

    always #5 Clk = ~Clk;

    alu_display_core #(
        .WIDTH    (W),
        .DIGITS   (D),
        .SCAN_DIV (SD)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .sw         (sw),
        .pb_a       (pb_a),
        .pb_b       (pb_b),
        .pb_op      (pb_op),
        .LED        (LED),
        .carry      (carry),
        .busy       (busy),
        .AN_SEL     (AN_SEL),
        .digit_code (digit_code)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int alu_ref(input int a, input int b, input int op);
        case (op)
            0: return a + b;
            1: return (a >= b) ? (a - b) : (512 + a - b);
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            default: return a * 2;
        endcase
    endfunction

    function automatic int digit_of(input int v, input int i);
        int x = v;
        for (int k = 0; k < i; k++) x = x / 10;
        return x % 10;
    endfunction

    // Model: results become visible one edge after a load; a conversion starts on the
    // first free edge after a result, takes W+2 edges to reach the display, and picks
    // up the latest result if more arrived meanwhile.
    int m_a, m_b, m_op, m_res, m_disp, conv_val, conv_start, cyc, n_scan, idx;
    int disp_old, op_old;
    bit m_recomp, m_want, m_active, p_a, p_b, p_op, m_valid;
    int e_led, e_carry, e_busy, e_an, e_dig;

    initial begin
        cyc = 0;
        m_valid = 0;
    end

    always @(posedge Clk) begin
        cyc = cyc + 1;
        if (Reset) begin
            m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_disp = 0;
            m_recomp = 0; m_want = 0; m_active = 0;
            p_a = 0; p_b = 0; p_op = 0;
            n_scan = 0;
            e_an = 14;
            e_dig = 0;
        end else begin
            disp_old = m_disp;
            op_old   = m_op;
            if (m_active && cyc == conv_start + W + 2) begin
                m_disp   = conv_val;
                m_active = 0;
            end else if (!m_active && m_want) begin
                conv_val   = m_res;
                conv_start = cyc;
                m_active   = 1;
                m_want     = 0;
            end
            if (m_recomp) begin
                m_res  = alu_ref(m_a, m_b, m_op);
                m_want = 1;
            end
            m_recomp = 0;
            if (pb_a && !p_a)   begin m_a = int'(sw); m_recomp = 1; end
            if (pb_b && !p_b)   begin m_b = int'(sw); m_recomp = 1; end
            if (pb_op && !p_op) begin m_op = (m_op + 1) % 6; m_recomp = 1; end
            p_a = pb_a; p_b = pb_b; p_op = pb_op;
            n_scan = n_scan + 1;
            idx    = (n_scan / SD) % D;
            e_an   = (~(1 << idx)) & ((1 << D) - 1);
            e_dig  = (idx == D - 1) ? (10 + op_old) : digit_of(disp_old, idx);
        end
        e_led   = m_res % 256;
        e_carry = (m_res / 256) % 2;
        e_busy  = m_active ? 1 : 0;
        m_valid = 1;
    end

    always @(negedge Clk) begin
        if (m_valid) begin
            check("led", 32'(LED), e_led);
            check("carry", 32'(carry), e_carry);
            check("busy", 32'(busy), e_busy);
            check("an_sel", 32'(AN_SEL), e_an);
            check("digit_code", 32'(digit_code), e_dig);
        end
    end

    task automatic pulse(input int which, input int val);
        sw = W'(val);
        case (which)
            0: pb_a = 1'b1;
            1: pb_b = 1'b1;
            default: pb_op = 1'b1;
        endcase
        @(negedge Clk);
        pb_a = 1'b0; pb_b = 1'b0; pb_op = 1'b0;
        @(negedge Clk);
    endtask

    task automatic wait_busy(input logic level, input int limit, input string name);
        int k = 0;
        while (busy !== level && k < limit) begin
            @(negedge Clk);
            k++;
        end
        check(name, 32'(busy), 32'(level));
    endtask

    task automatic read_digits(output logic [4*D-1:0] d);
        logic [D-1:0] m;
        d = '0;
        for (int i = 0; i < D * SD + 1; i++) begin
            @(negedge Clk);
            for (int j = 0; j < D; j++) begin
                m = D'(1) << j;
                if (AN_SEL == ~m) d[4*j +: 4] = digit_code;
            end
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    logic [D-1:0]   an_tbl [5];
    logic [4*D-1:0] digs;
    int lat, busy_cnt;
    bit seen;

    initial begin
        an_tbl[0] = 4'b1110; an_tbl[1] = 4'b1101; an_tbl[2] = 4'b1011;
        an_tbl[3] = 4'b0111; an_tbl[4] = 4'b1110;
        Reset = 1'b1; sw = '0; pb_a = 1'b0; pb_b = 1'b0; pb_op = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        check("rst_led", 32'(LED), 0);
        check("rst_carry", 32'(carry), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_an", 32'(AN_SEL), 32'b1110);
        check("rst_digit", 32'(digit_code), 0);

        settle(3);
        for (int i = 0; i < 5; i++) begin
            check("scan_step", 32'(AN_SEL), 32'(an_tbl[i]));
            if (i == 3) check("scan_letter", 32'(digit_code), 32'hA);
            settle(4);
        end

        pulse(0, 200);
        wait_busy(1'b1, 20, "a_conv_start");
        wait_busy(1'b0, 20, "a_conv_end");
        pulse(1, 100);
        lat = 1; busy_cnt = 0; seen = 0;
        while (lat < 40 && !(seen && busy == 1'b0)) begin
            @(negedge Clk);
            lat++;
            if (busy) begin seen = 1; busy_cnt++; end
        end
        check("add_latency", lat, 12);
        check("add_busy_len", busy_cnt, 10);
        check("add_led", 32'(LED), 32'h2C);
        check("add_carry", 32'(carry), 1);
        check("model_disp_300", m_disp, 300);
        read_digits(digs);
        check("add_digits", 32'(digs), 32'hA300);

        pulse(2, 0);
        wait_busy(1'b1, 20, "sub_conv_start");
        wait_busy(1'b0, 20, "sub_conv_end");
        check("sub_led", 32'(LED), 100);
        check("sub_carry", 32'(carry), 0);
        read_digits(digs);
        check("sub_digits", 32'(digs), 32'hB100);

        pulse(0, 5);
        settle(16);
        pulse(1, 9);
        wait_busy(1'b1, 20, "sub2_conv_start");
        wait_busy(1'b0, 20, "sub2_conv_end");
        check("sub2_led", 32'(LED), 32'hFC);
        check("sub2_carry", 32'(carry), 1);
        check("model_disp_508", m_disp, 508);
        read_digits(digs);
        check("sub2_digits", 32'(digs), 32'hB508);

        pb_op = 1'b1;
        settle(40);
        pb_op = 1'b0;
        settle(20);
        read_digits(digs);
        check("hold_op_once", 32'(digs), 32'hC001);

        for (int i = 0; i < 4; i++) pulse(2, 0);
        settle(40);
        read_digits(digs);
        check("op_to_add", 32'(digs), 32'hA014);
        for (int i = 0; i < 6; i++) pulse(2, 0);
        settle(40);
        read_digits(digs);
        check("op_wrap", 32'(digs), 32'hA014);

        pulse(0, 77);
        wait_busy(1'b1, 20, "pend_first_start");
        settle(1);
        pulse(1, 150);
        wait_busy(1'b0, 20, "pend_first_end");
        settle(1);
        check("pend_restart", 32'(busy), 1);
        wait_busy(1'b0, 20, "pend_second_end");
        check("pend_led", 32'(LED), 227);
        read_digits(digs);
        check("pend_digits", 32'(digs), 32'hA227);

        pulse(0, 33);
        wait_busy(1'b1, 20, "rstconv_start");
        settle(2);
        Reset = 1'b1;
        @(negedge Clk);
        check("rstconv_busy", 32'(busy), 0);
        check("rstconv_an", 32'(AN_SEL), 32'b1110);
        check("rstconv_digit", 32'(digit_code), 0);
        Reset = 1'b0;
        read_digits(digs);
        check("rstconv_digits", 32'(digs), 32'hA000);

        for (int i = 0; i < 400; i++) begin
            sw    = W'($urandom);
            pb_a  = ($urandom_range(0, 5) == 0);
            pb_b  = ($urandom_range(0, 5) == 0);
            pb_op = ($urandom_range(0, 7) == 0);
            @(negedge Clk);
        end
        pb_a = 1'b0; pb_b = 1'b0; pb_op = 1'b0;
        settle(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
